alu_arbiter: RTL

- Shares the single combinational alu between two requesters: port 0 (CPU execute stage) and port 1 (auxiliary engine, e.g. address generator or DMA).
- Arbitrates round-robin, registers the winner's operands onto the ALU inputs and captures result/psrOut into a response register.
- Returns the response to the owning requester with a valid/ready handshake.
- Sits between the requesters and the alu instance, which lives one level up and connects through the alu* ports.

---
 rtl/alu_arbiter_pkg.sv | 26 ++
 rtl/alu_arbiter_if.sv | 35 +++
 rtl/alu_arbiter_rr_arbiter2.sv | 17 +
 rtl/alu_arbiter.sv | 72 +++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared widths, ALU opcodes, PSR bit positions and arbiter state encoding.
// Pure definitions: no logic, no latency, no backpressure.
package alu_arbiter_pkg;
    localparam int DW       = 16;
    localparam int OPW      = 4;
    localparam int PW       = 4;
    localparam int ARB_NREQ = 2;

    localparam logic [OPW-1:0] ALUOp_ADD = 4'd0;
    localparam logic [OPW-1:0] ALUOp_SUB = 4'd1;
    localparam logic [OPW-1:0] ALUOp_AND = 4'd2;
    localparam logic [OPW-1:0] ALUOp_OR  = 4'd3;
    localparam logic [OPW-1:0] ALUOp_XOR = 4'd4;
    localparam logic [OPW-1:0] ALUOp_MOV = 4'd5;

    localparam int PSR_C = 0;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 2;
    localparam int PSR_V = 3;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_DONE = 2'd2
    } arbState_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of the shared-ALU arbiter.
// master = surrounding requesters plus ALU; slave = the arbiter itself.
interface alu_arbiter_if;
    import alu_arbiter_pkg::*;

    logic [ARB_NREQ-1:0] reqValid;
    logic [ARB_NREQ-1:0] reqReady;
    logic [OPW-1:0]      reqOp0;
    logic [OPW-1:0]      reqOp1;
    logic [DW-1:0]       reqSrc0;
    logic [DW-1:0]       reqSrc1;
    logic [DW-1:0]       reqDst0;
    logic [DW-1:0]       reqDst1;
    logic [ARB_NREQ-1:0] respValid;
    logic [ARB_NREQ-1:0] respReady;
    logic [DW-1:0]       respResult;
    logic [PW-1:0]       respPsr;
    logic [OPW-1:0]      aluOp;
    logic [DW-1:0]       aluSrc;
    logic [DW-1:0]       aluDst;
    logic [DW-1:0]       aluResult;
    logic [PW-1:0]       aluPsr;

    modport master (
        output reqValid, reqOp0, reqOp1, reqSrc0, reqSrc1, reqDst0, reqDst1,
        output respReady, aluResult, aluPsr,
        input  reqReady, respValid, respResult, respPsr, aluOp, aluSrc, aluDst
    );

    modport slave (
        input  reqValid, reqOp0, reqOp1, reqSrc0, reqSrc1, reqDst0, reqDst1,
        input  respReady, aluResult, aluPsr,
        output reqReady, respValid, respResult, respPsr, aluOp, aluSrc, aluDst
    );
endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Combinational 2-way round-robin grant: a lone requester wins, a tie goes to
// the requester that was not granted last. Zero latency, holds no state.
module alu_arbiter_rr_arbiter2 (
    input  logic [1:0] reqValid,
    input  logic       lastGrant,
    output logic       grantValid,
    output logic       grantIdx
);
    always_comb begin
        grantValid = |reqValid;
        if (reqValid == 2'b11) begin
            grantIdx = ~lastGrant;
        end else begin
            grantIdx = reqValid[1];
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, round-robin, one op at a time.
// Response valid two cycles after the accept cycle; held in DONE until the owner's respReady.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    arbState_t state;
    logic      owner;
    logic      lastGrant;
    logic      grantValid;
    logic      grantIdx;

    alu_arbiter_rr_arbiter2 uRr (
        .reqValid   (bus.reqValid),
        .lastGrant  (lastGrant),
        .grantValid (grantValid),
        .grantIdx   (grantIdx)
    );

    // Accept is only offered in IDLE, so an operation never overlaps the next.
    always_comb begin
        bus.reqReady = '0;
        if (state == ARB_IDLE && grantValid) begin
            bus.reqReady[grantIdx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ARB_IDLE;
            owner          <= 1'b0;
            lastGrant      <= 1'b1;
            bus.aluOp      <= '0;
            bus.aluSrc     <= '0;
            bus.aluDst     <= '0;
            bus.respResult <= '0;
            bus.respPsr    <= '0;
            bus.respValid  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grantValid) begin
                        bus.aluOp  <= grantIdx ? bus.reqOp1  : bus.reqOp0;
                        bus.aluSrc <= grantIdx ? bus.reqSrc1 : bus.reqSrc0;
                        bus.aluDst <= grantIdx ? bus.reqDst1 : bus.reqDst0;
                        owner      <= grantIdx;
                        lastGrant  <= grantIdx;
                        state      <= ARB_EXEC;
                    end
                end
                ARB_EXEC: begin
                    bus.respResult <= bus.aluResult;
                    bus.respPsr    <= bus.aluPsr;
                    bus.respValid  <= owner ? 2'b10 : 2'b01;
                    state          <= ARB_DONE;
                end
                ARB_DONE: begin
                    if (bus.respReady[owner]) begin
                        bus.respValid <= '0;
                        state         <= ARB_IDLE;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end
endmodule
